i2c_bus_monitor: RTL
====================

Name: i2c_bus_monitor

Overview:
Parametrised successor to the single-byte I2C sniffer in the logic-analyzer front end.
- Passively watches SCL/SDA pins and detects START, repeated START and STOP.
- Captures each 8-bit byte together with its 9th-bit ACK/NACK, and flags the first byte after a START as the address byte.
- Buffers records in a small FIFO with a valid/ready handshake toward the capture/UART path.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on SCL and SDA; legal range 2..4.
- FIFO_DEPTH, 4: record FIFO entries; power of two, legal range 2..16.
- FILTER_LEN, 3: consecutive identical samples needed to change a filtered level. Used only with I2C_GLITCH_FILTER_EN; legal range 2..8.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- scl  in  1  raw I2C clock pin, asynchronous.
- sda  in  1  raw I2C data pin, asynchronous.
- detect_only  in  1  1 = condition detection only; no records are pushed.
- out_ready  in  1  consumer accepts the head record.
- clear_ovf  in  1  single-cycle pulse that clears the overflow flag.
- out_data  out  8  head record byte, MSB first on the wire.
- out_ack  out  1  head record ACK (1 = SDA low on the 9th bit).
- out_addr  out  1  head record is the first byte after a START or repeated START.
- out_valid  out  1  FIFO not empty.
- start_pulse  out  1  one-cycle pulse on START or repeated START.
- stop_pulse  out  1  one-cycle pulse on STOP.
- bus_busy  out  1  high from START until STOP.
- overflow  out  1  sticky; set when a record is dropped because the FIFO is full.

Behaviour:
- Reset values: all outputs 0; sync and filtered lines 1 (idle bus); FSM IDLE; FIFO empty; bit counter 0; first-byte flag 0.
- Sync: SCL and SDA each pass through SYNC_STAGES flops to give scl_s/sda_s; scl_d/sda_d are registered copies of those.
- Events, evaluated every clk:
  - scl_rise = scl_s & ~scl_d.
  - START = scl_s & scl_d & sda_d & ~sda_s.
  - STOP = scl_s & scl_d & ~sda_d & sda_s.
- FSM states: IDLE, BITS, ACK.
  - START in any state → BITS, bit counter 0, shift register 0, first flag 1, bus_busy 1, start_pulse for 1 cycle. In BITS or ACK this is a repeated START; any partial byte is discarded.
  - STOP in any state → IDLE, bus_busy 0, stop_pulse for 1 cycle; partial byte discarded, no record pushed.
  - BITS: on scl_rise, shift sda_s into the LSB and increment the counter. After the 8th rise → ACK.
  - ACK: on scl_rise, form record {first, ~sda_s, byte} and push it unless detect_only is high. Clear first → BITS, counter 0.
  - IDLE: scl_rise is ignored.
  - START/STOP have priority over scl_rise in the same cycle; they cannot coincide by construction.
- Latency: a record is pushed on the clk edge where scl_rise is true in ACK. out_valid is high from the following cycle. Pin-to-out_valid latency is SYNC_STAGES+1 clk edges after the first edge that samples SCL high (+FILTER_LEN with the filter).
- FIFO is first-word-fall-through:
  - out_* reflect the head entry.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle are both performed and the count is unchanged. This is legal even when full.
  - Push while full and not popping: record dropped, overflow set.
  - overflow clears only on clear_ovf or reset; if clear_ovf coincides with a drop, set wins.
  - out_data/out_ack/out_addr are don't-care while out_valid is 0.
- detect_only: FSM and pulses run normally, nothing is pushed, and the FIFO still drains.
- Async reset mid-transfer: the FIFO empties, the FSM returns to IDLE, and the next START is required before capture resumes.

Optional Feature:
I2C_GLITCH_FILTER_EN
- Defined: a per-line filter sits after the synchroniser. A filtered line changes only after FILTER_LEN consecutive samples agree on the new level; shorter pulses are suppressed. Adds FILTER_LEN cycles of latency.
- Undefined: no filter; scl_s/sda_s come straight from the synchroniser and FILTER_LEN is unused.

Test Plan:
- START, 0xA4 ACK, 0x3C NACK, STOP, out_ready=1, each SCL phase 8 clk: records {addr=1,ack=1,0xA4} then {addr=0,ack=0,0x3C}; one start_pulse; one stop_pulse; bus_busy high between them.
- START, 0x90 ACK, repeated START, 0x91 ACK, 0x55 NACK, STOP: three records with addr flags 1,1,0; two start_pulses; bus_busy stays high across the repeated START.
- FIFO_DEPTH=4, out_ready=0, five bytes: out_valid=1, four records retained in order, overflow=1 after the 5th ACK bit; clear_ovf pulse → overflow=0.
- START, 5 data bits, STOP: no record, FSM IDLE, stop_pulse seen.
- detect_only=1 through a full 0xA4 transfer: start_pulse and stop_pulse occur, out_valid stays 0.
- rst_n low after the 4th bit of a byte, then a new START + 0x12 ACK: only {addr=1,ack=1,0x12} appears. With I2C_GLITCH_FILTER_EN, a 1-clk SDA low glitch while SCL is high gives no start_pulse.

Source files
------------

// File: rtl/i2c_bus_monitor.sv
// ---------------------------------------------------------------------------
// i2c_bus_monitor
//   Passive I2C bus monitor. Watches raw SCL/SDA, detects START, repeated
//   START and STOP, captures every byte with its ACK/NACK bit and marks the
//   first byte after a START as the address byte. Records are buffered in a
//   first-word-fall-through FIFO with a valid/ready handshake.
//
//   Optional feature macro: I2C_GLITCH_FILTER_EN
//     When defined, a per-line glitch filter of FILTER_LEN samples sits after
//     the synchroniser. When undefined, FILTER_LEN is unused.
//
//   Parameters:
//     SYNC_STAGES  synchroniser depth on SCL and SDA (2..4)
//     FIFO_DEPTH   record FIFO entries, power of two (2..16)
//     FILTER_LEN   consecutive agreeing samples to change a filtered level (2..8)
//
//   Ports:
//     clk, rst_n    system clock, asynchronous active-low reset
//     scl, sda      raw asynchronous I2C pins
//     detect_only   1 = detect conditions only, push no records
//     out_ready     consumer accepts the head record
//     clear_ovf     single-cycle pulse clearing the overflow flag
//     out_data      head record byte (MSB first on the wire)
//     out_ack       head record ACK (1 = SDA low on the 9th bit)
//     out_addr      head record is the first byte after a (repeated) START
//     out_valid     FIFO not empty
//     start_pulse   one-cycle pulse on START / repeated START
//     stop_pulse    one-cycle pulse on STOP
//     bus_busy      high from START until STOP
//     overflow      sticky, set when a record is dropped on a full FIFO
// ---------------------------------------------------------------------------
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda,
  input  logic       detect_only,
  input  logic       out_ready,
  input  logic       clear_ovf,
  output logic [7:0] out_data,
  output logic       out_ack,
  output logic       out_addr,
  output logic       out_valid,
  output logic       start_pulse,
  output logic       stop_pulse,
  output logic       bus_busy,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Elaboration-time parameter legality checks.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("i2c_bus_monitor: SYNC_STAGES out of range");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("i2c_bus_monitor: FIFO_DEPTH must be a power of two in 2..16");
  end
  if (FILTER_LEN < 2 || FILTER_LEN > 8) begin : g_bad_filter
    $error("i2c_bus_monitor: FILTER_LEN out of range");
  end

  typedef enum logic [1:0] {IDLE, BITS, ACK} state_t;

  // ---- stage p0: synchronisers (reset to idle-bus level 1) ----
  logic [SYNC_STAGES-1:0] scl_sync_p0;
  logic [SYNC_STAGES-1:0] sda_sync_p0;
  logic [1:0]             line_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_p0 <= '1;
      sda_sync_p0 <= '1;
    end else begin
      scl_sync_p0 <= {scl_sync_p0[SYNC_STAGES-2:0], scl};
      sda_sync_p0 <= {sda_sync_p0[SYNC_STAGES-2:0], sda};
    end
  end

  assign line_raw = {scl_sync_p0[SYNC_STAGES-1], sda_sync_p0[SYNC_STAGES-1]};

  logic scl_s;
  logic sda_s;

`ifdef I2C_GLITCH_FILTER_EN
  // ---- stage p1: glitch filter ----
  // A line follows its input only after FILTER_LEN consecutive samples
  // disagree with the current filtered level; any agreeing sample restarts
  // the count, so shorter pulses never propagate.
  localparam int FCW = $clog2(FILTER_LEN);
  logic [1:0]     filt_p1;
  logic [FCW-1:0] fcnt_p1 [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_p1    <= 2'b11;
      fcnt_p1[0] <= '0;
      fcnt_p1[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (line_raw[i] == filt_p1[i]) begin
          fcnt_p1[i] <= '0;
        end else if (fcnt_p1[i] == FCW'(FILTER_LEN - 1)) begin
          filt_p1[i] <= line_raw[i];
          fcnt_p1[i] <= '0;
        end else begin
          fcnt_p1[i] <= fcnt_p1[i] + 1'b1;
        end
      end
    end
  end

  assign scl_s = filt_p1[1];
  assign sda_s = filt_p1[0];
`else
  assign scl_s = line_raw[1];
  assign sda_s = line_raw[0];
`endif

  // ---- stage p2: delayed copies for edge / condition detection ----
  logic scl_d;
  logic sda_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  logic scl_rise;
  logic start_evt;
  logic stop_evt;

  assign scl_rise  = scl_s & ~scl_d;
  assign start_evt = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_evt  = scl_s & scl_d & ~sda_d & sda_s;

  // ---- protocol FSM ----
  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      first       <= 1'b0;
      start_pulse <= 1'b0;
      stop_pulse  <= 1'b0;
      bus_busy    <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      stop_pulse  <= 1'b0;
      if (start_evt) begin
        // Also covers repeated START: any partial byte is thrown away.
        state       <= BITS;
        bit_cnt     <= '0;
        shreg       <= '0;
        first       <= 1'b1;
        bus_busy    <= 1'b1;
        start_pulse <= 1'b1;
      end else if (stop_evt) begin
        state      <= IDLE;
        bit_cnt    <= '0;
        bus_busy   <= 1'b0;
        stop_pulse <= 1'b1;
      end else if (scl_rise) begin
        case (state)
          BITS: begin
            shreg   <= {shreg[6:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ACK;
          end
          ACK: begin
            first   <= 1'b0;
            bit_cnt <= '0;
            state   <= BITS;
          end
          default: ;
        endcase
      end
    end
  end

  // Record is written on the same edge that clocks the 9th SCL rise.
  logic       push;
  logic [9:0] rec;

  assign push = (state == ACK) & scl_rise & ~start_evt & ~stop_evt & ~detect_only;
  assign rec  = {first, ~sda_s, shreg};

  // ---- record FIFO (first-word-fall-through) ----
  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          rd_en;
  logic          wr_en;
  logic          drop;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign rd_en = out_valid & out_ready;
  assign wr_en = push & (~full | rd_en);
  assign drop  = push & full & ~rd_en;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= rec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // A drop in the same cycle as clear_ovf keeps the flag set.
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  // Head fields are forced to 0 while empty so nothing stale leaks out.
  logic [9:0] head;

  assign out_valid = (count != '0);
  assign head      = out_valid ? mem[rd_ptr] : 10'd0;
  assign out_addr  = head[9];
  assign out_ack   = head[8];
  assign out_data  = head[7:0];

endmodule
